// File: rtl/req_grant_arbiter8.sv
// req_grant_arbiter8: single-owner request/grant arbiter with hold watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin; fixed priority otherwise.
module req_grant_arbiter8 #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic [2:0]   gnt_id,
  output logic         gnt_valid,
  output logic         timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [2:0]       id_q, id_d;
  logic             vld_q, vld_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             win_found;
  logic [2:0]       win_id;
  logic             own_req;
  logic             hold_hit;
  logic             rel;

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] rr_q, rr_d;
  logic [2:0] idx;

  // Winner: first requester at or after the rotating pointer.
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    idx       = 3'd0;
    for (int k = 0; k < N; k++) begin
      idx = rr_q + 3'(k);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Pointer moves past the owner on each release.
  always_comb begin
    rr_d = rr_q;
    if (state_q == GRANT && rel) begin
      rr_d = id_q + 3'd1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 3'd0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Winner: lowest set request index.
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_id    = 3'(i);
      end
    end
  end
`endif

  assign own_req  = req[id_q];
  assign hold_hit = (cnt_q == CNT_W'(MAX_HOLD));
  assign rel      = done | ~own_req | hold_hit;

  // Next state and registered outputs.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_id;
          id_d    = win_id;
          vld_d   = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          id_d    = 3'd0;
          vld_d   = 1'b0;
          cnt_d   = '0;
          to_d    = hold_hit & ~done & own_req;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= 3'd0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = vld_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_req_grant_arbiter8.sv
// tb_req_grant_arbiter8: directed table and sequences for req_grant_arbiter8.
// Works in both fixed-priority and ARB_ROUND_ROBIN_EN builds.
module tb_req_grant_arbiter8;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       vld;
    logic       to;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks;
  int errors;
  vec_t tbl[$];

  req_grant_arbiter8 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [7:0] q, logic d,
                              logic [7:0] g, logic [2:0] i,
                              logic v, logic t);
    vec_t x;
    x.rst = r; x.req = q; x.done = d;
    x.gnt = g; x.id = i; x.vld = v; x.to = t;
    return x;
  endfunction

  task automatic chk(string nm, logic [7:0] eg, logic [2:0] ei,
                     logic ev, logic et);
    checks++;
    if (gnt !== eg || gnt_id !== ei || gnt_valid !== ev || timeout !== et) begin
      errors++;
      $display("FAIL %s: got gnt=%h id=%0d v=%b to=%b, want gnt=%h id=%0d v=%b to=%b",
               nm, gnt, gnt_id, gnt_valid, timeout, eg, ei, ev, et);
    end
    checks++;
    if (gnt_valid !== (|gnt) || $countones(gnt) > 1 ||
        (gnt_valid && gnt[gnt_id] !== 1'b1)) begin
      errors++;
      $display("FAIL %s invariant: gnt=%h id=%0d v=%b", nm, gnt, gnt_id, gnt_valid);
    end
  endtask

  task automatic step(logic r, logic [7:0] q, logic d);
    rst = r; req = q; done = d;
    @(posedge clk);
    #1;
  endtask

  // Grant req bit b then hold it to the watchdog edge (16 granted cycles).
  task automatic hold16(string nm, logic [7:0] q, logic [2:0] b);
    for (int c = 0; c < 16; c++) begin
      step(1'b0, q, 1'b0);
      chk(nm, q, b, 1'b1, 1'b0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; req = 8'h00; done = 1'b0;
    // reset with all requests high
    tbl.push_back(mk(1, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 8'hFF, 0, 8'h00, 0, 0, 0));
    // fixed-priority pick, done after three granted cycles
    tbl.push_back(mk(0, 8'h2C, 0, 8'h04, 2, 1, 0));
    tbl.push_back(mk(0, 8'h2C, 0, 8'h04, 2, 1, 0));
    tbl.push_back(mk(0, 8'h2C, 0, 8'h04, 2, 1, 0));
    tbl.push_back(mk(0, 8'h2C, 1, 8'h00, 0, 0, 0));
`ifdef ARB_ROUND_ROBIN_EN
    tbl.push_back(mk(0, 8'h2C, 0, 8'h08, 3, 1, 0));
`else
    tbl.push_back(mk(0, 8'h2C, 0, 8'h04, 2, 1, 0));
`endif
    tbl.push_back(mk(0, 8'h2C, 1, 8'h00, 0, 0, 0));
    // done in IDLE ignored
    tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 0, 0));
    // non-owner change ignored, owner drop releases
    tbl.push_back(mk(0, 8'h08, 0, 8'h08, 3, 1, 0));
    tbl.push_back(mk(0, 8'h0C, 0, 8'h08, 3, 1, 0));
    tbl.push_back(mk(0, 8'h04, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h04, 0, 8'h04, 2, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0));
    // reset mid-tenure drops grant without timeout
    tbl.push_back(mk(0, 8'h08, 0, 8'h08, 3, 1, 0));
    tbl.push_back(mk(1, 8'h08, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h08, 0, 8'h08, 3, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].done);
      chk($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].vld, tbl[i].to);
    end

    // watchdog on requester 5, then regrant
    hold16("hold5", 8'h20, 3'd5);
    step(1'b0, 8'h20, 1'b0);
    chk("timeout5", 8'h00, 3'd0, 1'b0, 1'b1);
    step(1'b0, 8'h20, 1'b0);
    chk("regrant5", 8'h20, 3'd5, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("drop5", 8'h00, 3'd0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("idle5", 8'h00, 3'd0, 1'b0, 1'b0);

    // done plus owner drop on the watchdog cycle
    hold16("hold1", 8'h02, 3'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("done_drop_max", 8'h00, 3'd0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("idle1", 8'h00, 3'd0, 1'b0, 1'b0);

    // done wins on the watchdog cycle
    hold16("hold6", 8'h40, 3'd6);
    step(1'b0, 8'h40, 1'b1);
    chk("done_max", 8'h00, 3'd0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("idle6", 8'h00, 3'd0, 1'b0, 1'b0);

    // all requesting, done every tenure
    step(1'b1, 8'hFF, 1'b0);
    chk("rst_all", 8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      logic [2:0] e;
`ifdef ARB_ROUND_ROBIN_EN
      e = 3'(k);
`else
      e = 3'd0;
`endif
      step(1'b0, 8'hFF, 1'b0);
      chk($sformatf("all_g%0d", k), 8'h01 << e, e, 1'b1, 1'b0);
      step(1'b0, 8'hFF, 1'b1);
      chk($sformatf("all_r%0d", k), 8'h00, 3'd0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
